fft_output_reorder: RTL and testbench
=====================================

Name: fft_output_reorder

Overview:
- Consumer-side block for the 4-lane radix-4 FFT pipeline (R4BFU/MDC/rotator datapath).
- Accepts 4 complex samples per beat in radix-4 digit-reversed order and emits them in natural order, 4 per beat.
- Ping-pong double buffer so one frame fills while the previous one drains.
- Valid/ready handshake on both sides; sits between the FFT core outputs Q0..Q3 and the downstream sink.

Parameters:
- DW, 64, sample width: {REAL[DW-1:DW/2], IMAG[DW/2-1:0]}, two's complement; passed through unmodified.
- LOG4N, 3, frame size N = 4^LOG4N points (64); beats per frame B = N/4; legal range 2..4.

Ports:
- CLK  input  1  clock, all logic on rising edge.
- RST  input  1  reset, synchronous, active-high.
- IN_VALID  input  1  input beat valid.
- IN_READY  output  1  block can accept a beat.
- IN_SOF  input  1  marks beat 0 of a frame; qualified by IN_VALID.
- D0..D3  input  DW each  input lanes 0..3.
- OUT_VALID  output  1  output beat valid.
- OUT_READY  input  1  sink accepts beat.
- OUT_LAST  output  1  high on final beat (B-1) of a frame.
- Q0..Q3  output  DW each  output lanes 0..3.
- SOF_ERR  output  1  sticky frame-alignment error.

Behaviour:
- Decided: one clock CLK; reset RST is synchronous and active-high.
- Index map: input beat b, lane l gives slot s = 4*b + l (2*LOG4N bits, base-4 digits s = d[LOG4N-1]..d[0]). Natural index k is s with base-4 digit order reversed. Output beat o, lane m carries natural index 4*o + m.
- Storage: two banks (BANK0, BANK1) of N words each. Write pointer WB, read pointer RB, write beat counter WC, read beat counter RC.
- Per-bank state: EMPTY -> FILLING (first accepted beat) -> FULL (beat B-1 accepted) -> DRAINING (first output beat presented) -> EMPTY (beat B-1 accepted by sink).
- Input handshake:
  - IN_READY = 1 when bank[WB] is EMPTY or FILLING.
  - A beat is accepted when IN_VALID & IN_READY; it writes 4 words to bank[WB] at addresses k(s) and increments WC.
  - On WC = B-1: WC <= 0, bank[WB] goes FULL, WB toggles.
- Output handshake:
  - OUT_VALID = 1 when bank[RB] is FULL or DRAINING.
  - Qm = bank[RB][4*RC + m]; OUT_LAST = OUT_VALID & (RC = B-1).
  - A beat transfers when OUT_VALID & OUT_READY; RC increments. On RC = B-1: RC <= 0, bank[RB] goes EMPTY, RB toggles.
  - OUT_VALID, Q and OUT_LAST are stable while OUT_READY is low.
  - Q0..Q3 = 0 whenever OUT_VALID = 0.
- Latency: OUT_VALID rises the cycle after the last input beat of a frame is accepted.
- Throughput: continuous 1 beat/cycle on both sides with no bubbles when OUT_READY is held high.
- Simultaneous events: a bank draining its last beat and the writer needing that bank in the same cycle is not a conflict. The EMPTY transition is visible to IN_READY the next cycle. Fill-complete and drain-complete on opposite banks in one cycle are both honoured.
- Both banks FULL/DRAINING: IN_READY = 0. No overflow possible; no underflow possible.
- IN_SOF:
  - With WC = 0: normal.
  - With WC != 0: set SOF_ERR, discard partial bank[WB] contents by setting WC <= 0, and write this beat as beat 0. Bank stays FILLING.
  - IN_SOF is not required. Frames are delimited by count alone.
- SOF_ERR clears only on RST.
- Reset (RST=1 on an edge, including mid-frame): WB = RB = 0, WC = RC = 0, both banks EMPTY, OUT_VALID = 0, OUT_LAST = 0, Q = 0, SOF_ERR = 0, IN_READY = 1 the cycle after RST deasserts. Bank contents are not cleared.

Test Plan:
- Ordering (LOG4N=3): load lane value = k(s) for one frame, OUT_READY=1 -> output beat o lanes = {4o, 4o+1, 4o+2, 4o+3} for o = 0..15. Spot checks: input beat 0 carries k = {0,16,32,48}; input beat 1 lane 0 carries k = 4; output beat 0 is sourced from input beats 0/4/8/12, lane 0.
- Latency/throughput: 4 frames back-to-back, IN_VALID=OUT_READY=1 -> first OUT_VALID 1 cycle after input beat 15; 64 output beats with no gaps; OUT_LAST on output beats 15, 31, 47, 63.
- Backpressure: OUT_READY=0, stream 3 frames -> IN_READY drops after beat 31 is accepted. Raise OUT_READY -> frame 0 drains intact; IN_READY returns the cycle after frame 0's last output beat. Q is held stable while stalled.
- SOF misalignment: IN_SOF on input beat 5 -> SOF_ERR=1 (sticky); frame restarts, and the output frame contains only the 16 beats from the IN_SOF beat onward in correct order.
- Mid-frame reset: RST for 1 cycle during input beat 7 with a full bank draining -> next cycle OUT_VALID=0, Q=0, IN_READY=1, SOF_ERR=0. The next full frame reorders correctly.
- Random: random IN_VALID/OUT_READY (50%), 20 frames, compared against a reference model -> zero mismatches, no lost or duplicated beats.

Source files
------------

// File: rtl/fft_output_reorder.sv
// -----------------------------------------------------------------------------
// fft_output_reorder
//
// Consumer-side reorder buffer for the 4-lane radix-4 FFT pipeline. Each input
// beat carries four complex samples in radix-4 digit-reversed order. The block
// writes them into a ping-pong pair of banks at their natural-order addresses.
// It then reads each completed bank out sequentially, four natural-order
// samples per beat. One bank fills while the other drains.
//
// Parameters
//   DW     sample width, {REAL[DW-1:DW/2], IMAG[DW/2-1:0]}, passed through as is
//   LOG4N  frame size N = 4**LOG4N points, B = N/4 beats per frame (2..4)
//
// Ports
//   CLK        clock, all logic on the rising edge
//   RST        synchronous active-high reset
//   IN_VALID   input beat valid
//   IN_READY   block can accept an input beat
//   IN_SOF     marks beat 0 of a frame (qualified by IN_VALID)
//   D0..D3     input lanes 0..3 (digit-reversed order)
//   OUT_VALID  output beat valid
//   OUT_READY  sink accepts the output beat
//   OUT_LAST   final beat (B-1) of an output frame
//   Q0..Q3     output lanes 0..3 (natural order), zero while OUT_VALID is low
//   SOF_ERR    sticky: IN_SOF arrived in the middle of a frame
// -----------------------------------------------------------------------------
module fft_output_reorder #(
  parameter int DW    = 64,
  parameter int LOG4N = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic          IN_SOF,
  input  logic [DW-1:0] D0,
  input  logic [DW-1:0] D1,
  input  logic [DW-1:0] D2,
  input  logic [DW-1:0] D3,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic          OUT_LAST,
  output logic [DW-1:0] Q0,
  output logic [DW-1:0] Q1,
  output logic [DW-1:0] Q2,
  output logic [DW-1:0] Q3,
  output logic          SOF_ERR
);

  localparam int N  = 4 ** LOG4N;
  localparam int B  = N / 4;
  localparam int AW = 2 * LOG4N;   // sample address width within a bank
  localparam int BW = AW - 2;      // beat counter width

  localparam logic [BW-1:0] LAST_BEAT = BW'(B - 1);

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_state_t;

  bank_state_t      bank_state     [2];
  bank_state_t      bank_state_nxt [2];
  logic             wb;            // bank being written
  logic             rb;            // bank being read
  logic [BW-1:0]    wc;            // write beat counter
  logic [BW-1:0]    rc;            // read beat counter
  logic             sof_err;
  logic [DW-1:0]    mem [2][N];

  logic             in_fire;
  logic             out_fire;
  logic             sof_restart;
  logic [BW-1:0]    wbeat;         // beat index this input beat is stored as
  logic             wlast;
  logic             rlast;

  // Reverse the base-4 digits of a slot index to get its natural index.
  function automatic logic [AW-1:0] digit_rev(input logic [AW-1:0] s);
    logic [AW-1:0] r;
    r = '0;
    for (int i = 0; i < LOG4N; i++) begin
      r[2*(LOG4N-1-i) +: 2] = s[2*i +: 2];
    end
    return r;
  endfunction

  assign in_fire     = IN_VALID && IN_READY;
  assign out_fire    = OUT_VALID && OUT_READY;
  // A start-of-frame mid-frame throws away the partial frame: the beat is
  // stored as beat 0 and the count restarts from there.
  assign sof_restart = in_fire && IN_SOF && (wc != '0);
  assign wbeat       = IN_SOF ? '0 : wc;
  assign wlast       = (wbeat == LAST_BEAT);
  assign rlast       = (rc == LAST_BEAT);
  assign SOF_ERR     = sof_err;

  // ---------------------------------------------------------------------------
  // Bank state register and control counters
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 2; i++) begin
        bank_state[i] <= EMPTY;
      end
      wb      <= 1'b0;
      rb      <= 1'b0;
      wc      <= '0;
      rc      <= '0;
      sof_err <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        bank_state[i] <= bank_state_nxt[i];
      end
      if (in_fire) begin
        wc <= wlast ? '0 : wbeat + BW'(1);
        if (wlast) begin
          wb <= ~wb;
        end
      end
      if (sof_restart) begin
        sof_err <= 1'b1;
      end
      if (out_fire) begin
        rc <= rlast ? '0 : rc + BW'(1);
        if (rlast) begin
          rb <= ~rb;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sample storage
  // ---------------------------------------------------------------------------
  // NOTE: the banks are deliberately not reset; stale contents are never
  // visible because a bank is only read after a complete frame is written.
  always_ff @(posedge CLK) begin
    if (in_fire) begin
      mem[wb][digit_rev({wbeat, 2'd0})] <= D0;
      mem[wb][digit_rev({wbeat, 2'd1})] <= D1;
      mem[wb][digit_rev({wbeat, 2'd2})] <= D2;
      mem[wb][digit_rev({wbeat, 2'd3})] <= D3;
    end
  end

  // ---------------------------------------------------------------------------
  // Bank next-state logic. The writer only touches an EMPTY/FILLING bank and
  // the reader only a FULL/DRAINING one, so both can act in the same cycle.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      bank_state_nxt[i] = bank_state[i];
      if (in_fire && (wb == 1'(i))) begin
        bank_state_nxt[i] = wlast ? FULL : FILLING;
      end
      if (OUT_VALID && (rb == 1'(i))) begin
        bank_state_nxt[i] = (out_fire && rlast) ? EMPTY : DRAINING;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from registered state only
  // ---------------------------------------------------------------------------
  always_comb begin
    IN_READY  = (bank_state[wb] == EMPTY) || (bank_state[wb] == FILLING);
    OUT_VALID = (bank_state[rb] == FULL) || (bank_state[rb] == DRAINING);
    OUT_LAST  = OUT_VALID && rlast;
    Q0 = '0;
    Q1 = '0;
    Q2 = '0;
    Q3 = '0;
    if (OUT_VALID) begin
      Q0 = mem[rb][{rc, 2'd0}];
      Q1 = mem[rb][{rc, 2'd1}];
      Q2 = mem[rb][{rc, 2'd2}];
      Q3 = mem[rb][{rc, 2'd3}];
    end
  end

endmodule

// File: tb/tb_fft_output_reorder.sv
// -----------------------------------------------------------------------------
// tb_fft_output_reorder
//
// Directed bench for fft_output_reorder at DW=64, LOG4N=3 (N=64, B=16).
// Each input lane carries {frame tag, natural index k(s)}. Output beat o, lane m
// must therefore read {frame tag, 4*o+m}. A negedge monitor checks every output
// beat, OUT_LAST, stall stability and the idle-zero rule. Its expectations come
// from the queue of frame tags that the driver completes.
// -----------------------------------------------------------------------------
module tb_fft_output_reorder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sof = 1'b0;
  logic [63:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic [63:0] q0, q1, q2, q3;
  logic        sof_err;
  logic [63:0] q_arr [4];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Driver-side model.
  logic [31:0] exp_tags [$];
  int          wcnt      = 0;
  int          in_waits  = 0;
  bit          lat_probe = 1'b0;
  bit          lat_pending = 1'b0;

  // Monitor state.
  bit          mon_en = 1'b0;
  int          obeat = 0;
  int          frames_out = 0;
  int          out_count = 0;
  int          first_out_cyc = 0;
  int          last_out_cyc = 0;
  bit          stalled_prev = 1'b0;
  logic [63:0] held_q0, held_q3;
  logic        held_last;
  bit          rnd_done = 1'b0;
  int          f_base;

  fft_output_reorder #(.DW(64), .LOG4N(3)) dut (
    .CLK       (clk),
    .RST       (rst),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .IN_SOF    (in_sof),
    .D0        (d0),
    .D1        (d1),
    .D2        (d2),
    .D3        (d3),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .OUT_LAST  (out_last),
    .Q0        (q0),
    .Q1        (q1),
    .Q2        (q2),
    .Q3        (q3),
    .SOF_ERR   (sof_err)
  );

  assign q_arr[0] = q0;
  assign q_arr[1] = q1;
  assign q_arr[2] = q2;
  assign q_arr[3] = q3;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Natural index of slot s for N=64: digits d2 d1 d0 become d0 d1 d2.
  function automatic int kmap(input int s);
    return (s % 4) * 16 + ((s / 4) % 4) * 4 + (s / 16);
  endfunction

  function automatic logic [63:0] mk(input logic [31:0] tag, input int b, input int l);
    return {tag, 32'(kmap(4 * b + l))};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic drive_beat(input int b, input bit sof, input logic [31:0] tag);
    int w;
    bit probe_hit;
    probe_hit = 1'b0;
    in_valid = 1'b1;
    in_sof   = sof;
    d0 = mk(tag, b, 0);
    d1 = mk(tag, b, 1);
    d2 = mk(tag, b, 2);
    d3 = mk(tag, b, 3);
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 1000) begin
      w++;
      in_waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("in_accept_timeout", 64'(in_ready), 64'd1);
    end else begin
      if (sof && wcnt != 0) wcnt = 0;
      if (wcnt == 15) begin
        exp_tags.push_back(tag);
        wcnt = 0;
        if (lat_probe) begin
          check("lat_pre_valid", 64'(out_valid), 64'd0);
          probe_hit = 1'b1;
        end
      end else begin
        wcnt++;
      end
    end
    @(posedge clk);
    #1;
    if (probe_hit) lat_pending = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] tag);
    for (int b = 0; b < 16; b++) drive_beat(b, 1'b0, tag);
  endtask

  task automatic wait_drain(input int max_cyc);
    int w;
    w = 0;
    while ((exp_tags.size() != 0 || out_valid) && w < max_cyc) begin
      @(negedge clk);
      w++;
    end
    if (exp_tags.size() != 0 || out_valid)
      check("drain_timeout", 64'(exp_tags.size()) + 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (lat_pending) begin
        check("lat_post_valid", 64'(out_valid), 64'd1);
        lat_pending = 1'b0;
      end
      if (stalled_prev) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_q0", q0, held_q0);
        check("stall_q3", q3, held_q3);
        check("stall_last", 64'(out_last), 64'(held_last));
      end
      if (out_valid) begin
        if (out_ready) begin
          if (exp_tags.size() == 0) begin
            check("spurious_beat", 64'(out_valid), 64'd0);
          end else begin
            for (int m = 0; m < 4; m++)
              check($sformatf("q%0d_beat%0d", m, obeat), q_arr[m],
                    {exp_tags[0], 32'(4 * obeat + m)});
            check($sformatf("out_last_beat%0d", obeat), 64'(out_last), 64'(obeat == 15));
            if (obeat == 15) begin
              obeat = 0;
              void'(exp_tags.pop_front());
              frames_out++;
            end else begin
              obeat++;
            end
          end
          if (out_count == 0) first_out_cyc = cyc;
          last_out_cyc = cyc;
          out_count++;
        end
      end else begin
        check("idle_q_zero", q0 | q1 | q2 | q3, 64'd0);
        check("idle_last", 64'(out_last), 64'd0);
      end
      stalled_prev = out_valid && !out_ready;
      held_q0   = q0;
      held_q3   = q3;
      held_last = out_last;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_sof_err", 64'(sof_err), 64'd0);
    check("rst_q_zero", q0 | q1 | q2 | q3, 64'd0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // ---------------- ordering, one frame ----------------
    out_ready = 1'b1;
    send_frame(32'h1);
    wait_drain(200);
    check("t1_frames", 64'(frames_out), 64'd1);
    check("t1_sof_err", 64'(sof_err), 64'd0);

    // ---------------- latency / throughput, 4 frames ----------------
    out_count = 0;
    in_waits  = 0;
    f_base    = frames_out;
    for (int f = 0; f < 4; f++) begin
      lat_probe = (f == 0);
      send_frame(32'h20 + 32'(f));
    end
    lat_probe = 1'b0;
    wait_drain(200);
    check("tput_frames", 64'(frames_out - f_base), 64'd4);
    check("tput_beats", 64'(out_count), 64'd64);
    check("tput_span", 64'(last_out_cyc - first_out_cyc), 64'd63);
    check("tput_in_stalls", 64'(in_waits), 64'd0);

    // ---------------- backpressure ----------------
    out_ready = 1'b0;
    f_base = frames_out;
    send_frame(32'h30);
    send_frame(32'h31);
    @(negedge clk);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 15) begin
        check("bp_frame0_last", 64'(out_last), 64'd1);
        check("bp_in_ready_hold", 64'(in_ready), 64'd0);
      end
    end
    @(negedge clk);
    check("bp_in_ready_back", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    send_frame(32'h32);
    wait_drain(200);
    check("bp_frames", 64'(frames_out - f_base), 64'd3);

    // ---------------- SOF misalignment ----------------
    f_base = frames_out;
    drive_beat(0, 1'b1, 32'h40);
    for (int b = 1; b < 5; b++) drive_beat(b, 1'b0, 32'h40);
    check("sof_err_before", 64'(sof_err), 64'd0);
    drive_beat(0, 1'b1, 32'h41);
    check("sof_err_set", 64'(sof_err), 64'd1);
    for (int b = 1; b < 16; b++) drive_beat(b, 1'b0, 32'h41);
    wait_drain(200);
    check("sof_frames", 64'(frames_out - f_base), 64'd1);
    check("sof_err_sticky", 64'(sof_err), 64'd1);

    // ---------------- mid-frame reset ----------------
    out_ready = 1'b0;
    send_frame(32'h50);
    out_ready = 1'b1;
    for (int b = 0; b < 7; b++) drive_beat(b, 1'b0, 32'h51);
    mon_en   = 1'b0;
    in_valid = 1'b1;
    d0 = mk(32'h51, 7, 0);
    d1 = mk(32'h51, 7, 1);
    d2 = mk(32'h51, 7, 2);
    d3 = mk(32'h51, 7, 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    exp_tags.delete();
    wcnt = 0;
    obeat = 0;
    stalled_prev = 1'b0;
    lat_pending  = 1'b0;
    @(negedge clk);
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_q_zero", q0 | q1 | q2 | q3, 64'd0);
    check("mrst_in_ready", 64'(in_ready), 64'd1);
    check("mrst_sof_err", 64'(sof_err), 64'd0);
    check("mrst_out_last", 64'(out_last), 64'd0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    f_base = frames_out;
    send_frame(32'h52);
    wait_drain(200);
    check("mrst_frames", 64'(frames_out - f_base), 64'd1);

    // ---------------- random handshakes, 20 frames ----------------
    f_base = frames_out;
    out_count = 0;
    fork
      begin
        for (int f = 0; f < 20; f++) begin
          for (int b = 0; b < 16; b++) begin
            while ($urandom_range(1, 0) == 1) begin
              in_valid = 1'b0;
              @(posedge clk);
              #1;
            end
            drive_beat(b, 1'b0, 32'h100 + 32'(f));
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = ($urandom_range(1, 0) == 1);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain(2000);
    check("rand_frames", 64'(frames_out - f_base), 64'd20);
    check("rand_beats", 64'(out_count), 64'd320);
    check("rand_leftover", 64'(exp_tags.size()), 64'd0);
    check("rand_sof_err", 64'(sof_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
